// File: rtl/pps_pkg.sv
// Shared types and defaults for the PPS phase meter.
package pps_pkg;

  localparam int PPS_CLK_HZ = 125_000_000;
  localparam int PPS_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_REF = 2'd2
  } pps_state_e;

endpackage

// File: rtl/pps_sync_edge.sv
// DEPTH-flop synchronizer followed by one history flop; stb_o is a 1-cycle rising-edge strobe.
// Total front-end delay is DEPTH cycles to the strobe, identical for every instance.
module pps_sync_edge
  import pps_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic stb_o
);

  logic [DEPTH-1:0] sync_q;
  logic             last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
      last_q <= sync_q[DEPTH-1];
    end
  end

  assign stb_o = sync_q[DEPTH-1] & ~last_q;

endmodule

// File: rtl/pps_phase_meter.sv
// Signed offset (t_in - t_ref, clk cycles) between local and remote PPS edges, streamed on valid/ready.
// Optional PPS_PERIOD_EN: measures remote PPS period on in_period_o; otherwise that output is 0.
module pps_phase_meter
  import pps_pkg::*;
#(
  parameter int CLK_HZ      = PPS_CLK_HZ,
  parameter int CNT_W       = PPS_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = CLK_HZ / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pps_ref_i,
  input  logic             pps_in_i,
  output logic [CNT_W-1:0] m_offset_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             err_timeout_o,
  output logic             overrun_o,
  input  logic             clr_overrun_i,
  output logic [CNT_W-1:0] in_period_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pps_phase_meter: SYNC_STAGES must be >= 2");
  end
  if (longint'(WINDOW) >= (longint'(1) << (CNT_W - 1))) begin : g_bad_window
    $error("pps_phase_meter: WINDOW must be below 2**(CNT_W-1)");
  end

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

  logic ref_stb;
  logic in_stb;

  // Same depth on both paths so the strobes carry no relative skew.
  pps_sync_edge #(.DEPTH(SYNC_STAGES)) u_sync_ref (
    .clk   (clk),
    .rst   (rst),
    .d_i   (pps_ref_i),
    .stb_o (ref_stb)
  );

  pps_sync_edge #(.DEPTH(SYNC_STAGES)) u_sync_in (
    .clk   (clk),
    .rst   (rst),
    .d_i   (pps_in_i),
    .stb_o (in_stb)
  );

  pps_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   emit;
  logic signed [CNT_W-1:0] emit_off;
  logic                   tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ref_stb && !in_stb) begin
          state_d = ST_WAIT_IN;
          cnt_d   = CNT_W'(1);
        end else if (in_stb && !ref_stb) begin
          state_d = ST_WAIT_REF;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT_IN: begin
        if (in_stb) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (ref_stb) begin
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == WIN_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_REF: begin
        if (ref_stb) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (in_stb) begin
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == WIN_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The partner edge always takes priority over a repeated edge or the window expiry.
  always_comb begin
    emit     = 1'b0;
    emit_off = '0;
    tmo      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ref_stb && in_stb) begin
          emit = 1'b1;
        end
      end
      ST_WAIT_IN: begin
        if (in_stb) begin
          emit     = 1'b1;
          emit_off = $signed(cnt_q);
        end else if (ref_stb || cnt_q == WIN_C) begin
          tmo = 1'b1;
        end
      end
      ST_WAIT_REF: begin
        if (ref_stb) begin
          emit     = 1'b1;
          emit_off = -$signed(cnt_q);
        end else if (in_stb || cnt_q == WIN_C) begin
          tmo = 1'b1;
        end
      end
      default: begin
        emit = 1'b0;
      end
    endcase
  end

  logic             vld_q, vld_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic             ovr_q, ovr_d;
  logic             tmo_q;
  logic             accept;

  assign accept = !vld_q || m_ready_i;

  always_comb begin
    vld_d = vld_q;
    off_d = off_q;
    ovr_d = ovr_q;
    if (emit && accept) begin
      vld_d = 1'b1;
      off_d = emit_off;
    end else if (vld_q && m_ready_i) begin
      vld_d = 1'b0;
    end
    if (emit && !accept) begin
      ovr_d = 1'b1;
    end else if (clr_overrun_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      off_q <= '0;
      ovr_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      off_q <= off_d;
      ovr_q <= ovr_d;
      tmo_q <= tmo;
    end
  end

  assign m_valid_o     = vld_q;
  assign m_offset_o    = off_q;
  assign overrun_o     = ovr_q;
  assign err_timeout_o = tmo_q;

`ifdef PPS_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] per_cnt_inc;

  assign per_cnt_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CNT_W'(1);

  // Counter sits at 0 on the strobe cycle, so the elapsed period is count+1.
  always_comb begin
    per_cnt_d = per_cnt_inc;
    per_d     = per_q;
    seen_d    = seen_q;
    if (in_stb) begin
      per_cnt_d = '0;
      seen_d    = 1'b1;
      if (seen_q) begin
        per_d = per_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
      per_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      per_q     <= per_d;
      seen_q    <= seen_d;
    end
  end

  assign in_period_o = per_q;
`else
  assign in_period_o = '0;
`endif

endmodule
